// File: rtl/periph_bus_master.sv
// periph_bus_master: queues single-bit read/write requests and issues them to an 8-bit peripheral window
module periph_bus_master #(
  parameter logic [31:0] PERIPH_BASE = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] periph_address,
  output logic [31:0] periph_write_data,
  output logic        periph_should_write,
  input  logic [31:0] periph_read_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic [33:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [33:0] cmd_q, cmd_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic push, pop, cmd_write, cmd_bit, in_win, issue;
  logic [31:0] cmd_addr;
  logic unused_bits;
  assign unused_bits = ^{req_data[31:1], periph_read_data[31:1]};
  assign cmd_write = cmd_q[33];
  assign cmd_addr = cmd_q[32:1];
  assign cmd_bit = cmd_q[0];
  assign in_win = cmd_addr[31:3] == PERIPH_BASE[31:3];
  assign req_ready = !reset && count_q != (AW+1)'(FIFO_DEPTH);
  assign push = req_valid && req_ready;
  assign pop = state_q == IDLE && count_q != '0;
  // Outputs are forced to zero combinationally so the reset cycle itself is quiet.
  assign issue = state_q == ISSUE && !reset;
  assign periph_should_write = issue && cmd_write && in_win;
  assign periph_address = reset ? '0 : (issue ? cmd_addr : paddr_q);
  assign periph_write_data = reset ? '0 : (periph_should_write ? {cmd_bit, 31'b0} : pwdata_q);
  assign resp_valid = rvalid_q && !reset;
  assign resp_data = reset ? '0 : rdata_q;
  assign resp_error = rerr_q && !reset;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    state_d = state_q;
    cmd_d = cmd_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d = rdata_q;
    rvalid_d = rvalid_q;
    rerr_d = rerr_q;
    case (state_q)
      IDLE: begin
        rerr_d = 1'b0;
        cmd_d = pop ? fifo_q[rd_ptr_q] : cmd_q;
        state_d = pop ? ISSUE : IDLE;
      end
      ISSUE: begin
        paddr_d = cmd_addr;
        pwdata_d = (cmd_write && in_win) ? {cmd_bit, 31'b0} : pwdata_q;
        rerr_d = !in_win;
        rvalid_d = !cmd_write;
        rdata_d = cmd_write ? rdata_q : {31'b0, in_win & periph_read_data[0]};
        state_d = cmd_write ? IDLE : RESP;
      end
      RESP: begin
        rvalid_d = resp_ready ? 1'b0 : rvalid_q;
        rerr_d = resp_ready ? 1'b0 : rerr_q;
        state_d = resp_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {req_write, req_address, req_data[0]};
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      cmd_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      cmd_q <= cmd_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q <= rerr_d;
    end
  end
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: scoreboard bench with a behavioural 8-bit responder
module tb_periph_bus_master;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_address = '0, req_data = '0;
  logic resp_valid, resp_ready = 1'b0, resp_error, periph_should_write;
  logic [31:0] resp_data, periph_address, periph_write_data, periph_read_data;
  logic [7:0] dev_bits = '0, ref_bits = '0;
  logic [1:0] sb [$];
  int checks = 0, errors = 0, strobe_cnt = 0, exp_strobes = 0;
  logic rr_rand = 1'b0;

  periph_bus_master dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error), .periph_address(periph_address),
    .periph_write_data(periph_write_data), .periph_should_write(periph_should_write),
    .periph_read_data(periph_read_data)
  );

  always #5 clock = ~clock;

  // Responder: junk in the upper bits so only bit 0 may be trusted.
  assign periph_read_data = {31'h5555_5555, dev_bits[periph_address[2:0]]};
  always @(posedge clock) if (periph_should_write === 1'b1) dev_bits[periph_address[2:0]] <= periph_write_data[31];

  always @(negedge clock) begin
    if (periph_should_write === 1'b1) strobe_cnt++;
    if (resp_valid === 1'b1 && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got data=%h err=%b, expected no response", resp_data, resp_error);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if (resp_data !== {31'b0, e[1]} || resp_error !== e[0]) begin
          errors++;
          $display("FAIL sb_resp: got data=%h err=%b, expected data=%h err=%b", resp_data, resp_error, {31'b0, e[1]}, e[0]);
        end
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic w, input logic [31:0] a, input logic d);
    int n = 0;
    logic inw;
    req_write = w;
    req_address = a;
    req_data = {$urandom};
    req_data[0] = d;
    req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready=%b, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    inw = a[31:3] == 29'h200;
    if (w && inw) begin
      ref_bits[a[2:0]] = d;
      exp_strobes++;
    end else if (!w) sb.push_back({inw ? ref_bits[a[2:0]] : 1'b0, !inw});
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_error, periph_should_write} !== 4'b0 || resp_data !== 0 || periph_address !== 0 || periph_write_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b re=%b sw=%b rd=%h pa=%h pw=%h, expected all 0", req_ready, resp_valid, resp_error, periph_should_write, resp_data, periph_address, periph_write_data);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b rv=%b, expected rdy=1 rv=0", req_ready, resp_valid);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_write();
    resp_ready = 1'b1;
    send(1'b1, 32'h1001, 1'b1);
    @(negedge clock);
    checks++;
    if (periph_should_write !== 1'b0) begin
      errors++;
      $display("FAIL write_early: got sw=%b, expected 0", periph_should_write);
    end
    @(negedge clock);
    checks++;
    if (periph_should_write !== 1'b1 || periph_address !== 32'h1001 || periph_write_data !== 32'h8000_0000) begin
      errors++;
      $display("FAIL write_strobe: got sw=%b pa=%h pw=%h, expected sw=1 pa=00001001 pw=80000000", periph_should_write, periph_address, periph_write_data);
    end
    @(negedge clock);
    checks++;
    if (periph_should_write !== 1'b0 || periph_address !== 32'h1001 || periph_write_data !== 32'h8000_0000) begin
      errors++;
      $display("FAIL write_after: got sw=%b pa=%h pw=%h, expected sw=0 pa=00001001 pw=80000000", periph_should_write, periph_address, periph_write_data);
    end
    drain();
  endtask

  task automatic test_read();
    resp_ready = 1'b1;
    send(1'b1, 32'h1006, 1'b1);
    drain();
    resp_ready = 1'b0;
    send(1'b0, 32'h1006, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_early: got rv=%b, expected 0", resp_valid);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h1 || resp_error !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: got rv=%b rd=%h re=%b, expected rv=1 rd=00000001 re=0", resp_valid, resp_data, resp_error);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h1) begin
      errors++;
      $display("FAIL read_hold: got rv=%b rd=%h, expected rv=1 rd=00000001", resp_valid, resp_data);
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    drain();
  endtask

  task automatic test_oow_write();
    int s0 = strobe_cnt;
    resp_ready = 1'b1;
    send(1'b1, 32'h2001, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (resp_error !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL oow_write_err: got re=%b rv=%b, expected re=1 rv=0", resp_error, resp_valid);
    end
    @(negedge clock);
    checks++;
    if (resp_error !== 1'b0 || strobe_cnt != s0) begin
      errors++;
      $display("FAIL oow_write_after: got re=%b strobes=%0d, expected re=0 strobes=%0d", resp_error, strobe_cnt, s0);
    end
    drain();
  endtask

  task automatic test_oow_read();
    int s0 = strobe_cnt;
    resp_ready = 1'b1;
    send(1'b0, 32'h2000, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 0 || resp_error !== 1'b1) begin
      errors++;
      $display("FAIL oow_read: got rv=%b rd=%h re=%b, expected rv=1 rd=0 re=1", resp_valid, resp_data, resp_error);
    end
    drain();
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL oow_read_strobe: got %0d, expected %0d", strobe_cnt, s0);
    end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    send(1'b0, 32'h1006, 1'b0);
    send(1'b0, 32'h1000, 1'b0);
    send(1'b0, 32'h2000, 1'b0);
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full: got rdy=%b, expected 0", req_ready);
      end
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_issue();
    logic [7:0] saved = ref_bits;
    int se = exp_strobes, s0 = strobe_cnt;
    resp_ready = 1'b1;
    send(1'b1, 32'h1003, 1'b1);
    ref_bits = saved;
    exp_strobes = se;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (periph_should_write !== 1'b0 || periph_address !== 0 || periph_write_data !== 0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_issue: got sw=%b pa=%h pw=%h rdy=%b, expected all 0", periph_should_write, periph_address, periph_write_data, req_ready);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_error, periph_should_write} !== 3'b0 || resp_data !== 0 || periph_address !== 0 || periph_write_data !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got rv=%b re=%b sw=%b rd=%h pa=%h pw=%h rdy=%b, expected zeros rdy=1", resp_valid, resp_error, periph_should_write, resp_data, periph_address, periph_write_data, req_ready);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (strobe_cnt != s0) begin
      errors++;
      $display("FAIL rst_no_strobe: got %0d, expected %0d", strobe_cnt, s0);
    end
    @(posedge clock);
    #1;
    send(1'b0, 32'h1003, 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] addrs [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h1008, 32'h0FF8, 32'h2000};
    rr_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 5)] + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)));
    end
    rr_rand = 1'b0;
    @(posedge clock);
    #1 resp_ready = 1'b1;
    drain();
    checks++;
    if (strobe_cnt != exp_strobes) begin
      errors++;
      $display("FAIL rand_strobes: got %0d, expected %0d", strobe_cnt, exp_strobes);
    end
    checks++;
    if (dev_bits !== ref_bits) begin
      errors++;
      $display("FAIL rand_bits: got %h, expected %h", dev_bits, ref_bits);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_oow_write();
    test_oow_read();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL have parameter PERIPH_BASE, default 32'h0000_1000, base address of the 8-bit peripheral window (bits [2:0] select the bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, request queue entries (power of two, 2..8).
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  requester offers a request.
REQ-006 req_ready  out  1  request queue can accept.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_address  in  32  byte address of the target bit.
REQ-009 req_data  in  32  write value; only bit 0 is used.
REQ-010 resp_valid  out  1  read response available.
REQ-011 resp_ready  in  1  consumer accepts the response.
REQ-012 resp_data  out  32  read result, zero-extended bit.
REQ-013 resp_error  out  1  response or dropped write addressed outside the window.
REQ-014 periph_address  out  32  address to the peripheral register file.
REQ-015 periph_write_data  out  32  write data; the peripheral samples bit 31.
REQ-016 periph_should_write  out  1  write strobe, one cycle per write.
REQ-017 periph_read_data  in  32  combinational read data; bit 0 is valid.

Function
REQ-018 SHALL accept a request on a posedge where req_valid && req_ready; req_ready = !fifo_full.
REQ-019 SHALL queue requests FIFO-ordered; a simultaneous push and pop when full SHALL NOT be allowed (req_ready is low when full, regardless of pop).
REQ-020 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-021 IDLE: if the FIFO is non-empty, pop the head into the command register and go to ISSUE; otherwise stay.
REQ-022 ISSUE, in-window write: drive periph_address = req_address, periph_write_data = {req_data[0], 31'b0}, periph_should_write = 1 for exactly this cycle, then go to IDLE with no response.
REQ-023 ISSUE, read: drive periph_address with periph_should_write = 0; at the closing posedge capture resp_data = {31'b0, periph_read_data[0]}, set resp_valid, and go to RESP.
REQ-024 In-window SHALL mean req_address[31:3] == PERIPH_BASE[31:3].
REQ-025 Out-of-window write: SHALL drop it without asserting periph_should_write and pulse resp_error for one cycle.
REQ-026 Out-of-window read: SHALL return resp_data = 0 with resp_error = 1 through RESP.
REQ-027 RESP: hold resp_valid, resp_data and resp_error stable until resp_valid && resp_ready, then go to IDLE; no new request is issued while in RESP.
REQ-028 Read latency SHALL be 3 posedges from acceptance into an empty idle FIFO to resp_valid: push, pop, capture.
REQ-029 Write latency SHALL be a strobe in the 2nd cycle after acceptance.
REQ-030 Outside ISSUE, periph_should_write SHALL be 0 and periph_address/periph_write_data SHALL hold their last values.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-032 While reset is high at a posedge, SHALL clear the FIFO and go to IDLE.
REQ-033 Reset SHALL drive resp_valid = 0, resp_data = 0, resp_error = 0, periph_should_write = 0, periph_address = 0, periph_write_data = 0, and req_ready = 0 during the reset cycle.
REQ-034 Reset asserted mid-ISSUE or mid-RESP SHALL abort the transaction; no strobe is issued after reset and the pending response is discarded.

Verification
REQ-035 Write 0x1001 data 1: periph_should_write high for exactly one cycle, 2 cycles after acceptance, with periph_address=0x1001 and periph_write_data=0x8000_0000.
REQ-036 Read 0x1006 with periph_read_data=1: resp_valid at the 3rd posedge, resp_data=0x1, resp_error=0.
REQ-037 Read 0x2000: resp_valid with resp_data=0, resp_error=1; periph_should_write stays 0 throughout.
REQ-038 Three back-to-back requests with resp_ready=0: req_ready low after 2 queued plus 1 in flight; order preserved after resp_ready rises.
REQ-039 Reset asserted during ISSUE of a write: no strobe, all outputs zero next cycle, FIFO empty.
REQ-040 Random mix of 1000 requests against a behavioural 8-bit responder model: all read data matches the model and the strobe count equals the number of in-window writes.
